// File: rtl/or_and_tree_loader.sv
// Serial operand loader and result capture stage in front of or_and_tree.
// Optional 8-bit completed-result counter enabled by OR_AND_TREE_LOADER_CNT_EN.
module or_and_tree_loader #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_bit_x,
  input  logic         in_bit_y,
  output logic [N-1:0] X,
  output logic [N-1:0] Y,
  input  logic         Z_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_z
`ifdef OR_AND_TREE_LOADER_CNT_EN
  ,
  output logic [7:0]   res_cnt
`endif
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [CW-1:0]  cnt_r;
  logic [N-1:0]   x_r;
  logic [N-1:0]   y_r;
  logic           out_z_r;
  logic           in_ready_r;
  logic           out_valid_r;
  logic           beat_s;
  logic           last_beat_s;

  assign beat_s      = in_valid && in_ready_r;
  assign last_beat_s = beat_s && (cnt_r == CW'(N - 1));

  // Next-state decode for the load/evaluate/hold sequence
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      LOAD: begin
        if (last_beat_s) begin
          state_nxt_s = EVAL;
        end else begin
          state_nxt_s = LOAD;
        end
      end
      EVAL: begin
        state_nxt_s = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt_s = LOAD;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = LOAD;
      end
    endcase
  end

  // State register; handshake flags are registered copies of the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= LOAD;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == LOAD);
      out_valid_r <= (state_nxt_s == HOLD);
    end
  end

  // Operand shift registers (LSB first) and beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r   <= {N{1'b0}};
      y_r   <= {N{1'b0}};
      cnt_r <= {CW{1'b0}};
    end else if (beat_s) begin
      x_r   <= {in_bit_x, x_r[N-1:1]};
      y_r   <= {in_bit_y, y_r[N-1:1]};
      cnt_r <= last_beat_s ? {CW{1'b0}} : (cnt_r + CW'(1));
    end
  end

  // Capture the settled tree output at the end of the evaluate cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_z_r <= 1'b0;
    end else if (state_r == EVAL) begin
      out_z_r <= Z_in;
    end
  end

`ifdef OR_AND_TREE_LOADER_CNT_EN
  logic [7:0] res_cnt_r;

  // Completed-result counter, wraps naturally at 8 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_cnt_r <= 8'd0;
    end else if (out_valid_r && out_ready) begin
      res_cnt_r <= res_cnt_r + 8'd1;
    end
  end

  assign res_cnt = res_cnt_r;
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_z     = out_z_r;
  assign X         = x_r;
  assign Y         = y_r;

endmodule

// File: tb/tb_or_and_tree_loader.sv
// Directed bench for or_and_tree_loader with N=8, 4 and 2 instances; the attached
// tree is modelled behaviourally (leaves X&Y, levels alternating, AND at the root).
module tb_or_and_tree_loader;

  logic clk;
  logic rst_n;
  logic bx, by;
  logic out_ready;
  logic iv8, iv4, iv2;
  logic ir8, ir4, ir2;
  logic ov8, ov4, ov2;
  logic oz8, oz4, oz2;
  logic z8, z4, z2;
  logic [7:0] x8, y8;
  logic [3:0] x4, y4;
  logic [1:0] x2, y2;
`ifdef OR_AND_TREE_LOADER_CNT_EN
  logic [7:0] rc8, rc4, rc2;
`endif

  int sel;
  int n_checks;
  int n_fail;

  function automatic logic tree_model(input logic [7:0] x, input logic [7:0] y, input int n);
    logic [7:0] v;
    int w;
    int lv;
    int levels;
    v = x & y;
    w = n;
    levels = $clog2(n);
    lv = 0;
    while (w > 1) begin
      lv++;
      for (int i = 0; i < w / 2; i++) begin
        v[i] = (((levels - lv) % 2) == 0) ? (v[2*i] & v[2*i+1]) : (v[2*i] | v[2*i+1]);
      end
      w = w / 2;
    end
    return v[0];
  endfunction

  assign z8 = tree_model(x8, y8, 8);
  assign z4 = tree_model({4'b0, x4}, {4'b0, y4}, 4);
  assign z2 = tree_model({6'b0, x2}, {6'b0, y2}, 2);

  or_and_tree_loader #(.N(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .in_bit_x(bx), .in_bit_y(by), .X(x8), .Y(y8), .Z_in(z8),
    .out_valid(ov8), .out_ready(out_ready), .out_z(oz8)
`ifdef OR_AND_TREE_LOADER_CNT_EN
    , .res_cnt(rc8)
`endif
  );

  or_and_tree_loader #(.N(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .in_bit_x(bx), .in_bit_y(by), .X(x4), .Y(y4), .Z_in(z4),
    .out_valid(ov4), .out_ready(out_ready), .out_z(oz4)
`ifdef OR_AND_TREE_LOADER_CNT_EN
    , .res_cnt(rc4)
`endif
  );

  or_and_tree_loader #(.N(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
    .in_bit_x(bx), .in_bit_y(by), .X(x2), .Y(y2), .Z_in(z2),
    .out_valid(ov2), .out_ready(out_ready), .out_z(oz2)
`ifdef OR_AND_TREE_LOADER_CNT_EN
    , .res_cnt(rc2)
`endif
  );

  logic       cur_ir, cur_ov, cur_oz;
  logic [7:0] cur_x, cur_y;
  assign cur_ir = (sel == 8) ? ir8 : (sel == 4) ? ir4 : ir2;
  assign cur_ov = (sel == 8) ? ov8 : (sel == 4) ? ov4 : ov2;
  assign cur_oz = (sel == 8) ? oz8 : (sel == 4) ? oz4 : oz2;
  assign cur_x  = (sel == 8) ? x8 : (sel == 4) ? {4'b0, x4} : {6'b0, x2};
  assign cur_y  = (sel == 8) ? y8 : (sel == 4) ? {4'b0, y4} : {6'b0, y2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic x, input logic y);
    iv8 = (sel == 8);
    iv4 = (sel == 4);
    iv2 = (sel == 2);
    bx  = x;
    by  = y;
    @(posedge clk);
    #1;
    iv8 = 1'b0;
    iv4 = 1'b0;
    iv2 = 1'b0;
    bx  = 1'b0;
    by  = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    sel = 8;
    rst_n = 1'b0;
    bx = 1'b0; by = 1'b0; out_ready = 1'b0;
    iv8 = 1'b0; iv4 = 1'b0; iv2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {7'b0, ir8}, 8'd1);
    chk("rst_out_valid", {7'b0, ov8}, 8'd0);
    chk("rst_out_z", {7'b0, oz8}, 8'd0);
    chk("rst_x", x8, 8'h00);
    chk("rst_y", y8, 8'h00);
    rst_n = 1'b1;
    idle();

    // FF/FF frame with downstream stalled for two cycles
    sel = 8;
    for (int i = 0; i < 8; i++) beat(1'b1, 1'b1);
    chk("ff_eval_in_ready", {7'b0, cur_ir}, 8'd0);
    chk("ff_eval_out_valid", {7'b0, cur_ov}, 8'd0);
    idle();
    chk("ff_hold_out_valid", {7'b0, cur_ov}, 8'd1);
    chk("ff_hold_out_z", {7'b0, cur_oz}, 8'd1);
    idle();
    idle();
    chk("ff_stall_out_valid", {7'b0, cur_ov}, 8'd1);
    chk("ff_stall_in_ready", {7'b0, cur_ir}, 8'd0);
    out_ready = 1'b1;
    idle();
    out_ready = 1'b0;
    chk("ff_after_hs_in_ready", {7'b0, cur_ir}, 8'd1);
    chk("ff_after_hs_out_valid", {7'b0, cur_ov}, 8'd0);

    // Back-to-back 00/FF then AA/AA with out_ready tied high
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) beat(1'b0, 1'b1);
    chk("r1_eval_x", cur_x, 8'h00);
    chk("r1_eval_y", cur_y, 8'hFF);
    idle();
    chk("r1_out_valid", {7'b0, cur_ov}, 8'd1);
    chk("r1_out_z", {7'b0, cur_oz}, 8'd0);
    idle();
    chk("r1_back_to_load", {7'b0, cur_ir}, 8'd1);
    for (int i = 0; i < 8; i++) beat(logic'(i % 2), logic'(i % 2));
    chk("r2_eval_x", cur_x, 8'hAA);
    chk("r2_eval_y", cur_y, 8'hAA);
    idle();
    chk("r2_out_valid", {7'b0, cur_ov}, 8'd1);
    chk("r2_out_z", {7'b0, cur_oz}, 8'd0);
    idle();
    out_ready = 1'b0;

    // N=4 with a three-cycle gap between beats 2 and 3
    sel = 4;
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b0);
    bx = 1'b1; by = 1'b1;
    repeat (3) idle();
    chk("gap_in_ready", {7'b0, cur_ir}, 8'd1);
    chk("gap_x_partial", cur_x, 8'h04);
    beat(1'b1, 1'b1);
    chk("gap_still_load", {7'b0, cur_ir}, 8'd1);
    beat(1'b0, 1'b0);
    chk("gap_eval_in_ready", {7'b0, cur_ir}, 8'd0);
    chk("gap_eval_x", cur_x, 8'h05);
    chk("gap_eval_y", cur_y, 8'h05);
    idle();
    chk("gap_out_valid", {7'b0, cur_ov}, 8'd1);
    chk("gap_out_z", {7'b0, cur_oz}, 8'd1);
    out_ready = 1'b1;
    idle();
    out_ready = 1'b0;

    // N=2 result held for ten cycles with out_ready low
    sel = 2;
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b0);
    idle();
    for (int i = 0; i < 10; i++) begin
      chk("hold_out_valid", {7'b0, cur_ov}, 8'd1);
      chk("hold_out_z", {7'b0, cur_oz}, 8'd0);
      chk("hold_x", cur_x, 8'h01);
      chk("hold_y", cur_y, 8'h01);
      chk("hold_in_ready", {7'b0, cur_ir}, 8'd0);
      bx = 1'b1; by = 1'b1; iv2 = 1'b1;
      idle();
      iv2 = 1'b0;
    end
    out_ready = 1'b1;
    idle();
    out_ready = 1'b0;
    chk("hold_released", {7'b0, cur_ir}, 8'd1);

    // Reset after five beats, then a clean FF/FF frame
    sel = 8;
    for (int i = 0; i < 5; i++) beat(1'b1, 1'b1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_x", cur_x, 8'h00);
    chk("mid_rst_y", cur_y, 8'h00);
    chk("mid_rst_out_valid", {7'b0, cur_ov}, 8'd0);
    idle();
    rst_n = 1'b1;
    idle();
    chk("post_rst_in_ready", {7'b0, cur_ir}, 8'd1);
    for (int i = 0; i < 7; i++) beat(1'b1, 1'b1);
    chk("post_rst_7_beats_load", {7'b0, cur_ir}, 8'd1);
    beat(1'b1, 1'b1);
    chk("post_rst_8_beats_eval", {7'b0, cur_ir}, 8'd0);
    idle();
    chk("post_rst_out_valid", {7'b0, cur_ov}, 8'd1);
    chk("post_rst_out_z", {7'b0, cur_oz}, 8'd1);
    out_ready = 1'b1;
    idle();
    out_ready = 1'b0;

`ifdef OR_AND_TREE_LOADER_CNT_EN
    chk("res_cnt_one", rc8, 8'd1);
    sel = 2;
    out_ready = 1'b1;
    for (int f = 0; f < 257; f++) begin
      beat(1'b1, 1'b1);
      beat(1'b1, 1'b1);
      idle();
      idle();
    end
    out_ready = 1'b0;
    chk("res_cnt_wrap", rc2, 8'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
